bp_resolve_queue: RTL and testbench
===================================

// Module: bp_resolve_queue
// PURPOSE
//   Resolution end of the 2-bit predictor loop. Holds in-flight predictions (pc, taken) in
//   program order and retires each against the actual branch outcome. Emits the registered
//   training update for the predictor, flags mispredicts and flushes wrong-path entries.
//   Sits between the fetch-side predictor and the execute-stage branch unit.
// PARAMETERS
//   DEPTH  4   in-flight prediction entries; power of 2, >= 2
//   PC_W   8   width of branch tag/pc carried per entry
//   CNT_W  16  width of statistics counters
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous, active-high reset
//   pred_valid  in   1      predictor presents a new prediction
//   pred_ready  out  1      queue can accept; = !full (combinational)
//   pred_taken  in   1      predicted direction, 1 = taken
//   pred_pc     in   PC_W   branch tag for the prediction
//   res_valid   in   1      execute resolves oldest in-flight branch
//   res_taken   in   1      actual direction, 1 = taken
//   upd_valid   out  1      registered 1-cycle pulse: train predictor
//   upd_pc      out  PC_W   tag of the retired entry
//   upd_taken   out  1      actual outcome (drives predictor "result")
//   mispredict  out  1      registered pulse, coincident with upd_valid
//   flush       out  1      registered pulse, asserted with mispredict
//   orphan      out  1      registered pulse: res_valid seen while empty
//   empty       out  1      no entries held (registered state)
//   full        out  1      DEPTH entries held (registered state)
//   correct_cnt out  CNT_W  saturating count of correct predictions
//   mispred_cnt out  CNT_W  saturating count of mispredictions
// BEHAVIOUR
//   - Reset: wr/rd pointers 0, count 0, empty=1, full=0, pred_ready=1; upd_valid, upd_pc,
//     upd_taken, mispredict, flush, orphan, correct_cnt, mispred_cnt all 0. Reset mid-op
//     discards all entries immediately; no update pulse generated.
//   - Pointers log2(DEPTH)+1 bits; full when MSBs differ and LSBs equal; natural wrap.
//   - Enqueue on pred_valid && pred_ready at clk edge; entry = {pred_pc, pred_taken}.
//   - Retire on res_valid && !empty: head popped; next cycle upd_valid=1, upd_pc=head.pc,
//     upd_taken=res_taken, mispredict=(head.taken != res_taken). Latency 1 cycle.
//   - res_valid && empty: no pop, no update; orphan=1 next cycle. No same-cycle bypass
//     of a simultaneously enqueued prediction.
//   - Mispredict retire: all entries cleared (count=0, rd=wr); flush=1 next cycle; any
//     enqueue in the same cycle is dropped (wrong path).
//   - Correct retire + enqueue in same cycle: both occur, count unchanged.
//   - full: pred_ready=0 even if a retire is in the same cycle (no full-bypass).
//   - Counters increment on each retire (correct or mispredict), saturate at all-ones.
//   - Pulsed outputs are 0 in every cycle without the qualifying event.
// CONFIGURATION
//   BP_RESOLVE_STATS_EN defined: correct_cnt / mispred_cnt implemented as above.
//   Not defined: counters not built; both outputs tied to 0; all other behaviour identical.
// STRUCTURE
//   bp_pkg: BP_TAKEN/BP_NOT_TAKEN constants, 2-bit counter state encodings shared with the
//     predictor, entry typedef {pc, taken}.
//   Sub-module bp_resolve_fifo: pointer/storage FIFO with push, pop, clear, full, empty;
//     top level holds compare, pulse registers and counters.
// TESTING
//   1. rst pulse mid-traffic -> empty=1, pred_ready=1, all pulses/counters 0 next cycle.
//   2. push (pc=0x12,T), resolve T -> upd_valid, upd_pc=0x12, upd_taken=1, mispredict=0,
//      correct_cnt=1.
//   3. push 4 entries -> full=1, pred_ready=0; 5th push ignored; 4 correct retires in
//      order -> upd_pc sequence matches pushes, empty=1.
//   4. push A(T),B(T),C(NT); resolve A as NT -> mispredict=1, flush=1, empty=1, B/C never
//      retired, mispred_cnt=1.
//   5. res_valid while empty with same-cycle push -> orphan=1, no upd_valid, entry held.
//   6. Force counters to all-ones (CNT_W=2 build) -> further retires hold at 3; without
//      BP_RESOLVE_STATS_EN both counters stay 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: direction constants, 2-bit counter states, entry layout.
package bp_pkg;

  localparam logic BP_TAKEN     = 1'b1;
  localparam logic BP_NOT_TAKEN = 1'b0;

  localparam int unsigned BP_PC_W = 8;

  typedef enum logic [1:0] {
    BpStrongNotTaken = 2'b00,
    BpWeakNotTaken   = 2'b01,
    BpWeakTaken      = 2'b10,
    BpStrongTaken    = 2'b11
  } bp_ctr_e;

  typedef struct packed {
    logic [BP_PC_W-1:0] pc;
    logic               taken;
  } bp_entry_t;

endpackage

// File: rtl/bp_resolve_fifo.sv
// In-order prediction FIFO: extra-MSB pointers, push/pop, clear (rd snaps to wr).
module bp_resolve_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full && !i_clear;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  // Clear wins over push and pop: wrong-path entries and any same-cycle push are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/bp_resolve_queue.sv
// Retires in-flight predictions against actual outcomes; registered train/mispredict pulses.
// Define BP_RESOLVE_STATS_EN to build the saturating correct/mispredict counters.
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pred_valid,
  output logic             o_pred_ready,
  input  logic             i_pred_taken,
  input  logic [PC_W-1:0]  i_pred_pc,
  input  logic             i_res_valid,
  input  logic             i_res_taken,
  output logic             o_upd_valid,
  output logic [PC_W-1:0]  o_upd_pc,
  output logic             o_upd_taken,
  output logic             o_mispredict,
  output logic             o_flush,
  output logic             o_orphan,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_correct_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  logic [PC_W:0]   w_head;
  logic            w_push;
  logic            w_pop;
  logic            w_mis;
  logic            r_upd_valid;
  logic [PC_W-1:0] r_upd_pc;
  logic            r_upd_taken;
  logic            r_mispredict;
  logic            r_orphan;

  assign o_pred_ready = !o_full;
  assign w_push       = i_pred_valid && o_pred_ready;
  assign w_pop        = i_res_valid && !o_empty;
  assign w_mis        = w_pop && (w_head[0] != i_res_taken);

  bp_resolve_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_mis),
    .i_wdata ({i_pred_pc, i_pred_taken}),
    .o_rdata (w_head),
    .o_full  (o_full),
    .o_empty (o_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upd_valid  <= 1'b0;
      r_upd_pc     <= '0;
      r_upd_taken  <= 1'b0;
      r_mispredict <= 1'b0;
      r_orphan     <= 1'b0;
    end else begin
      r_upd_valid  <= w_pop;
      r_upd_pc     <= w_pop ? w_head[PC_W:1] : '0;
      r_upd_taken  <= w_pop ? i_res_taken : BP_NOT_TAKEN;
      r_mispredict <= w_mis;
      r_orphan     <= i_res_valid && o_empty;
    end
  end

  assign o_upd_valid  = r_upd_valid;
  assign o_upd_pc     = r_upd_pc;
  assign o_upd_taken  = r_upd_taken;
  assign o_mispredict = r_mispredict;
  assign o_flush      = r_mispredict;
  assign o_orphan     = r_orphan;

`ifdef BP_RESOLVE_STATS_EN
  logic [CNT_W-1:0] r_correct_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_correct_cnt <= '0;
      r_mispred_cnt <= '0;
    end else if (w_pop) begin
      if (!w_mis && (r_correct_cnt != '1)) r_correct_cnt <= r_correct_cnt + 1'b1;
      if (w_mis && (r_mispred_cnt != '1))  r_mispred_cnt <= r_mispred_cnt + 1'b1;
    end
  end

  assign o_correct_cnt = r_correct_cnt;
  assign o_mispred_cnt = r_mispred_cnt;
`else
  assign o_correct_cnt = '0;
  assign o_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue (DEPTH=4, PC_W=8, CNT_W=2 to reach saturation).
module tb_bp_resolve_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pred_valid = 1'b0;
  logic       pred_taken = 1'b0;
  logic [7:0] pred_pc = '0;
  logic       res_valid = 1'b0;
  logic       res_taken = 1'b0;
  logic       pred_ready, upd_valid, upd_taken, mispredict, flush, orphan, empty, full;
  logic [7:0] upd_pc;
  logic [1:0] correct_cnt, mispred_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_c = 0;
  int exp_m = 0;

  always #5 clk = ~clk;

  bp_resolve_queue #(
    .DEPTH (4),
    .PC_W  (8),
    .CNT_W (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_pred_valid  (pred_valid),
    .o_pred_ready  (pred_ready),
    .i_pred_taken  (pred_taken),
    .i_pred_pc     (pred_pc),
    .i_res_valid   (res_valid),
    .i_res_taken   (res_taken),
    .o_upd_valid   (upd_valid),
    .o_upd_pc      (upd_pc),
    .o_upd_taken   (upd_taken),
    .o_mispredict  (mispredict),
    .o_flush       (flush),
    .o_orphan      (orphan),
    .o_empty       (empty),
    .o_full        (full),
    .o_correct_cnt (correct_cnt),
    .o_mispred_cnt (mispred_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] sat(input int v);
`ifdef BP_RESOLVE_STATS_EN
    logic [1:0] r;
    r = (v > 3) ? 2'd3 : 2'(v);
    return r;
`else
    return 2'd0;
`endif
  endfunction

  // Apply one cycle of inputs, sample 1 time unit after the edge, then go idle.
  task automatic cyc(input logic pv, input logic [7:0] pc, input logic pt,
                     input logic rv, input logic rt);
    pred_valid = pv; pred_pc = pc; pred_taken = pt; res_valid = rv; res_taken = rt;
    @(posedge clk); #1;
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; res_valid = 1'b0; res_taken = 1'b0;
  endtask

  task automatic check_upd(input string tag, input logic [7:0] pc, input logic tk,
                           input logic mis);
    check({tag, ".upd_valid"}, 32'(upd_valid), 32'd1);
    check({tag, ".upd_pc"}, 32'(upd_pc), 32'(pc));
    check({tag, ".upd_taken"}, 32'(upd_taken), 32'(tk));
    check({tag, ".mispredict"}, 32'(mispredict), 32'(mis));
    check({tag, ".flush"}, 32'(flush), 32'(mis));
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'd1);
    check({tag, ".full"}, 32'(full), 32'd0);
    check({tag, ".ready"}, 32'(pred_ready), 32'd1);
    check({tag, ".pulses"}, {28'd0, upd_valid, mispredict, flush, orphan}, 32'd0);
    check({tag, ".cnts"}, {28'd0, correct_cnt, mispred_cnt}, 32'd0);
  endtask

  logic [7:0] pcs [4];
  logic       tks [4];

  initial begin
    pcs[0] = 8'h21; pcs[1] = 8'h22; pcs[2] = 8'h23; pcs[3] = 8'h24;
    tks[0] = 1'b1;  tks[1] = 1'b0;  tks[2] = 1'b1;  tks[3] = 1'b0;

    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_idle_state("reset");

    // Single correct retire
    cyc(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    check("t2.empty", 32'(empty), 32'd0);
    check("t2.no_upd", 32'(upd_valid), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    exp_c++;
    check_upd("t2", 8'h12, 1'b1, 1'b0);
    check("t2.correct_cnt", 32'(correct_cnt), 32'(sat(exp_c)));
    check("t2.empty_after", 32'(empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t2.upd_pulse_end", 32'(upd_valid), 32'd0);

    // Fill, overflow attempt, drain in order
    for (int i = 0; i < 4; i++) cyc(1'b1, pcs[i], tks[i], 1'b0, 1'b0);
    check("t3.full", 32'(full), 32'd1);
    check("t3.ready", 32'(pred_ready), 32'd0);
    cyc(1'b1, 8'h25, 1'b1, 1'b0, 1'b0);
    check("t3.still_full", 32'(full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      // First retire also offers a push that must be refused while full
      cyc(i == 0, 8'h26, 1'b1, 1'b1, tks[i]);
      exp_c++;
      check_upd($sformatf("t3.ret%0d", i), pcs[i], tks[i], 1'b0);
      check($sformatf("t3.ret%0d.full", i), 32'(full), 32'd0);
    end
    check("t3.empty", 32'(empty), 32'd1);
    check("t3.correct_cnt", 32'(correct_cnt), 32'(sat(exp_c)));

    // Correct retire with same-cycle enqueue
    cyc(1'b1, 8'h51, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h52, 1'b0, 1'b1, 1'b1);
    exp_c++;
    check_upd("t3b.a", 8'h51, 1'b1, 1'b0);
    check("t3b.held", 32'(empty), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    exp_c++;
    check_upd("t3b.b", 8'h52, 1'b0, 1'b0);
    check("t3b.empty", 32'(empty), 32'd1);

    // Mispredict flushes wrong-path entries and a same-cycle push
    cyc(1'b1, 8'h31, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h32, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h34, 1'b1, 1'b1, 1'b0);
    exp_m++;
    check_upd("t4", 8'h31, 1'b0, 1'b1);
    check("t4.empty", 32'(empty), 32'd1);
    check("t4.mispred_cnt", 32'(mispred_cnt), 32'(sat(exp_m)));
    check("t4.correct_cnt", 32'(correct_cnt), 32'(sat(exp_c)));
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("t4.orphan_after_flush", 32'(orphan), 32'd1);
    check("t4.no_retire", {30'd0, upd_valid, flush}, 32'd0);

    // Resolve while empty, with same-cycle push: orphan, no bypass
    cyc(1'b1, 8'h41, 1'b1, 1'b1, 1'b1);
    check("t5.orphan", 32'(orphan), 32'd1);
    check("t5.no_upd", 32'(upd_valid), 32'd0);
    check("t5.held", 32'(empty), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t5.orphan_end", 32'(orphan), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    exp_c++;
    check_upd("t5.ret", 8'h41, 1'b1, 1'b0);

    // Drive mispredict counter into saturation
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      exp_m++;
      check($sformatf("t6.mis%0d", i), 32'(mispredict), 32'd1);
      check($sformatf("t6.mcnt%0d", i), 32'(mispred_cnt), 32'(sat(exp_m)));
    end
    check("t6.ccnt", 32'(correct_cnt), 32'(sat(exp_c)));

    // Asynchronous reset in the middle of traffic
    cyc(1'b1, 8'h71, 1'b1, 1'b0, 1'b0);
    pred_valid = 1'b1; pred_pc = 8'h72; pred_taken = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1 check_idle_state("midrst");
    pred_valid = 1'b0; res_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_state("midrst_post");
    exp_c = 0; exp_m = 0;
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("midrst.orphan", 32'(orphan), 32'd1);
    check("midrst.no_upd", 32'(upd_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
